// File: rtl/linebuf_pkg.sv
// linebuf_pkg: types shared by the ifmap streamer and the line-buffer path.
//   pixel_t : one 8-bit feature-map pixel
//   state_e : ifmap_streamer frame FSM states
//   beat_t  : one stream beat {data, eol, eof}
package linebuf_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      pixel_t data;
      logic   eol;
      logic   eof;
   } beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry first-word-fall-through FIFO of beat_t.
// The head entry drives dout_o directly, so it is held stable until popped.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears entries and count)
//   push_i     write din_i this cycle (caller guarantees space)
//   din_i      beat to write
//   pop_i      consumer takes the head this cycle (ignored when empty)
//   valid_o    head holds a beat
//   dout_o     head beat
//   count_o    number of stored beats (0..2)
module stream_skid_fifo
   import linebuf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  beat_t      din_i,
   input  logic       pop_i,
   output logic       valid_o,
   output beat_t      dout_o,
   output logic [1:0] count_o
);

   beat_t      head_q, head_d;
   beat_t      tail_q, tail_d;
   logic [1:0] count_q, count_d;
   logic       do_pop;

   assign do_pop = pop_i && (count_q != 2'd0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_i, do_pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = din_i;
            else                 tail_d = din_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // simultaneous: the pushed beat lands behind whatever is left
            if (count_q == 2'd1) begin
               head_d = din_i;
            end else begin
               head_d = tail_q;
               tail_d = din_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign dout_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/ifmap_streamer.sv
// ifmap_streamer: reads an IMG_H x IMG_W feature map from a 1-cycle-latency
// SRAM and streams it in raster order over valid/ready, optionally wrapped in
// a one-pixel zero border.
// Build option: IFMAP_STREAMER_ZERO_PAD_EN defined -> zero border (P=1),
//               undefined -> plain IMG_H x IMG_W frame (P=0).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, base_addr     frame request and SRAM start address (IDLE only)
//   busy, done           frame in progress / one-cycle completion pulse
//   mem_rd_en, mem_addr  SRAM read strobe and address
//   mem_rdata            SRAM data, valid the cycle after mem_rd_en
//   out_valid/out_ready  beat handshake
//   out_data/eol/eof     pixel, last column of row, last pixel of frame
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing one position per cycle while credit allows
// ST_DRAIN | all positions issued, waiting for FIFO and read pipe to empty
// ST_DONE  | done pulse, back to idle
module ifmap_streamer
   import linebuf_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_eol,
   output logic              out_eof
);

`ifdef IFMAP_STREAMER_ZERO_PAD_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   localparam int OUT_W = IMG_W + 2 * P;
   localparam int OUT_H = IMG_H + 2 * P;
   localparam int CW    = $clog2(OUT_W);
   localparam int RW    = $clog2(OUT_H);

   state_e            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
   logic              inflight_q, inflight_d;
   logic              tag_zero_q, tag_zero_d;
   logic              tag_eol_q, tag_eol_d;
   logic              tag_eof_q, tag_eof_d;

   logic              issue;
   logic              pop;
   logic              credit_ok;
   logic              last_col, last_row;
   logic              border, interior_row;
   logic [1:0]        fifo_count;
   logic [ADDR_W-1:0] rd_addr;
   beat_t             ret_beat;
   beat_t             head_beat;

   assign pop      = out_valid && out_ready;
   // a beat popping this cycle frees its slot for the read issued now
   assign credit_ok = (({1'b0, fifo_count} - {2'b00, pop}) + {2'b00, inflight_q}) < 3'd2;

   assign last_col     = (col_q == CW'(OUT_W - 1));
   assign last_row     = (row_q == RW'(OUT_H - 1));
   assign border       = (P != 0) && ((row_q == '0) || last_row || (col_q == '0) || last_col);
   assign interior_row = (P == 0) || ((row_q != '0) && !last_row);
   assign rd_addr      = row_ptr_q + ADDR_W'(col_q) - ADDR_W'(P);

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      row_ptr_d  = row_ptr_q;
      issue      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               row_ptr_d = base_addr;
               row_d     = '0;
               col_d     = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
                  if (interior_row) row_ptr_d = row_ptr_q + ADDR_W'(IMG_W);
                  if (last_row) state_d = ST_DRAIN;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if ((fifo_count == 2'd0) && !inflight_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      inflight_d = issue;
      tag_zero_d = border;
      tag_eol_d  = last_col;
      tag_eof_d  = last_col && last_row;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         row_ptr_q  <= '0;
         inflight_q <= 1'b0;
         tag_zero_q <= 1'b0;
         tag_eol_q  <= 1'b0;
         tag_eof_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         row_ptr_q  <= row_ptr_d;
         inflight_q <= inflight_d;
         tag_zero_q <= tag_zero_d;
         tag_eol_q  <= tag_eol_d;
         tag_eof_q  <= tag_eof_d;
      end
   end

   assign mem_rd_en = issue && !border;
   assign mem_addr  = mem_rd_en ? rd_addr : '0;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

   // return stage: border slots carry a zero instead of the SRAM word
   always_comb begin
      ret_beat.data = tag_zero_q ? 8'h00 : mem_rdata;
      ret_beat.eol  = tag_eol_q;
      ret_beat.eof  = tag_eof_q;
   end

   stream_skid_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .din_i   (ret_beat),
      .pop_i   (pop),
      .valid_o (out_valid),
      .dout_o  (head_beat),
      .count_o (fifo_count)
   );

   assign out_data = head_beat.data;
   assign out_eol  = head_beat.eol;
   assign out_eof  = head_beat.eof;

endmodule

// File: tb/tb_ifmap_streamer.sv
// tb_ifmap_streamer: randomized self-checking bench for ifmap_streamer
// (IMG_W=IMG_H=4, ADDR_W=8). Expected beats and SRAM addresses come from a
// raster-order frame model computed directly from the frame geometry.
module tb_ifmap_streamer;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int ADDR_W = 8;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int OUT_W = IMG_W + 2 * P;
   localparam int OUT_H = IMG_H + 2 * P;
   localparam int NB    = OUT_W * OUT_H;
   localparam int NRD   = IMG_W * IMG_H;
   localparam int BUDGET = 600;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              busy, done, mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_data;
   logic              out_eol, out_eof;

   ifmap_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_eol   (out_eol),
      .out_eof   (out_eof)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [9:0] exp_beat[$];
   logic [7:0] exp_addr[$];
   logic [9:0] got_beat[$];
   logic [7:0] got_addr[$];

   task automatic build_model(input logic [7:0] base);
      exp_beat.delete();
      exp_addr.delete();
      for (int r = 0; r < OUT_H; r++) begin
         for (int c = 0; c < OUT_W; c++) begin
            int ir = r - P;
            int ic = c - P;
            logic [7:0] a;
            logic [7:0] d;
            logic eol, eof;
            eol = (c == OUT_W - 1);
            eof = (r == OUT_H - 1) && eol;
            if (ir < 0 || ir >= IMG_H || ic < 0 || ic >= IMG_W) begin
               d = 8'h00;
            end else begin
               a = 8'(int'(base) + ir * IMG_W + ic);
               exp_addr.push_back(a);
               d = mem[a];
            end
            exp_beat.push_back({d, eol, eof});
         end
      end
   endtask

   // rmode: 0 ready high, 1 ready toggling, 2 random ready
   task automatic run_frame(input logic [7:0] base, input int rmode, input int pulse_at,
                            input int rst_at, input bit hold, input int nfr);
      int it, dones, first_rd, first_val, eof_it, rst_it;
      bit pulsed, rst_done, stall_prev, fin;
      logic [9:0] prev_beat;
      build_model(base);
      got_beat.delete();
      got_addr.delete();
      it = 0; dones = 0; first_rd = -1; first_val = -1; eof_it = -1; rst_it = -1;
      pulsed = 0; rst_done = 0; stall_prev = 0; fin = 0; prev_beat = '0;
      base_addr = base;
      while (!fin && it < BUDGET) begin
         @(negedge clk);
         start = (it == 0) || hold;
         if (pulse_at >= 0 && !pulsed && got_beat.size() == pulse_at) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         rst = 1'b0;
         if (rst_at >= 0 && !rst_done && got_beat.size() == rst_at) begin
            rst      = 1'b1;
            rst_done = 1'b1;
            rst_it   = it;
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (it % 2 == 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         #1;
         if (rst_done && it == rst_it + 1) begin
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_rd_en", mem_rd_en, 0);
            check_eq("rst_addr", mem_addr, 0);
            check_eq("rst_valid", out_valid, 0);
            check_eq("rst_beat", {out_data, out_eol, out_eof}, 0);
         end
         if (stall_prev) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_beat", {out_data, out_eol, out_eof}, prev_beat);
         end
         if (mem_rd_en) begin
            got_addr.push_back(mem_addr);
            if (first_rd < 0) first_rd = it;
         end
         if (out_valid && first_val < 0) first_val = it;
         if (out_valid && out_ready) begin
            got_beat.push_back({out_data, out_eol, out_eof});
            if (out_eof) eof_it = it;
         end
         stall_prev = out_valid && !out_ready && !rst;
         prev_beat  = {out_data, out_eol, out_eof};
         if (done) begin
            dones++;
            check_eq("busy_with_done", busy, 1);
            check_eq("done_after_eof", (eof_it >= 0 && it > eof_it), 1);
            if (dones == nfr) fin = 1;
         end
         if (nfr == 0 && rst_done && it == rst_it + 20) fin = 1;
         it++;
      end
      check_eq("timeout", fin, 1);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check_eq("busy_after", busy, 0);
      check_eq("done_after", done, 0);
      check_eq("first_rd_cycle", first_rd, 1);
      check_eq("first_valid_cycle", first_val, 3);
      if (nfr > 0) begin
         check_eq("done_count", dones, nfr);
         check_eq("beat_count", got_beat.size(), nfr * NB);
         check_eq("read_count", got_addr.size(), nfr * NRD);
         for (int i = 0; i < got_beat.size() && i < nfr * NB; i++)
            check_eq($sformatf("beat%0d", i), got_beat[i], exp_beat[i % NB]);
         for (int i = 0; i < got_addr.size() && i < nfr * NRD; i++)
            check_eq($sformatf("addr%0d", i), got_addr[i], exp_addr[i % NRD]);
         if (rmode == 0 && nfr == 1 && pulse_at < 0)
            check_eq("no_bubble", eof_it - first_val, NB - 1);
      end else begin
         check_eq("abort_no_done", dones, 0);
         check_eq("abort_beats_min", (got_beat.size() >= rst_at), 1);
         for (int i = 0; i < got_beat.size() && i < NB; i++)
            check_eq($sformatf("abort_beat%0d", i), got_beat[i], exp_beat[i]);
         for (int i = 0; i < got_addr.size() && i < NRD; i++)
            check_eq($sformatf("abort_addr%0d", i), got_addr[i], exp_addr[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_rd_en", mem_rd_en, 0);
      check_eq("reset_addr", mem_addr, 0);
      check_eq("reset_valid", out_valid, 0);
      check_eq("reset_beat", {out_data, out_eol, out_eof}, 0);
      @(negedge clk);
      rst = 1'b0;

      run_frame(8'h00, 0, -1, -1, 1'b0, 1);   // plain frame, ready high
      run_frame(8'h00, 1, -1, -1, 1'b0, 1);   // ready toggling
      run_frame(8'h00, 0, 5, -1, 1'b0, 1);    // stray start mid-frame
      run_frame(8'h00, 0, -1, -1, 1'b1, 2);   // start held: two frames
      run_frame(8'h00, 2, -1, 5, 1'b0, 0);    // reset after 5 beats
      run_frame(8'h00, 0, -1, -1, 1'b0, 1);   // restart from pixel 0
      run_frame(8'hFE, 0, -1, -1, 1'b0, 1);   // address wrap

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         run_frame(8'($urandom), 2, -1, -1, 1'b0, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
